// File: rtl/uart_bus_loader.sv
// UART-framed bus master: receives write/read frames, runs one 16-bit
// bus cycle per frame and answers over the UART transmitter.
module uart_bus_loader #(
  parameter int GAP_TIMEOUT = 16640,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  output logic        bus_req,
  output logic        bus_we,
  output logic [22:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        err
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [3:0] {
    IDLE, ADR2, ADR1, ADR0, DAT1, DAT0, BUS, TXB, TXW
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rsp_q, rsp_d;
  logic        two_q, two_d;
  logic        err_q, err_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW-1:0] ack_q, ack_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        seen_q, seen_d;
  logic [2:0]  wait_q, wait_d;
  logic        tx_done;

  assign tx_start  = tx_start_q;
  assign tx_byte   = tx_byte_q;
  assign bus_req   = (state_q == BUS);
  assign bus_we    = wr_q;
  assign bus_addr  = addr_q[23:1];
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  // A byte counts as sent once tx_active has pulsed, or after a short
  // wait if the transmitter never reports busy at all.
  assign tx_done = !tx_active &&
                   (seen_q || wait_q == 3'd4);

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    two_d      = two_q;
    err_d      = err_q;
    gap_d      = gap_q;
    ack_d      = ack_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    seen_d     = seen_q;
    wait_d     = wait_q;

    unique case (state_q)
      IDLE: begin
        if (rx_dv && (rx_byte == OP_WR ||
                      rx_byte == OP_RD)) begin
          wr_d    = (rx_byte == OP_WR);
          err_d   = 1'b0;
          gap_d   = '0;
          state_d = ADR2;
        end
      end
      ADR2, ADR1, ADR0, DAT1, DAT0: begin
        ack_d = '0;
        if (rx_dv) begin
          gap_d = '0;
          unique case (state_q)
            ADR2: begin
              addr_d[23:16] = rx_byte;
              state_d = ADR1;
            end
            ADR1: begin
              addr_d[15:8] = rx_byte;
              state_d = ADR0;
            end
            ADR0: begin
              addr_d[7:0] = rx_byte;
              state_d = wr_q ? DAT1 : BUS;
            end
            DAT1: begin
              wdata_d[15:8] = rx_byte;
              state_d = DAT0;
            end
            default: begin
              wdata_d[7:0] = rx_byte;
              state_d = BUS;
            end
          endcase
        end else if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      BUS: begin
        if (rx_dv) err_d = 1'b1;
        if (bus_ack) begin
          if (wr_q) begin
            rsp_d = {RSP_OK, 8'h00};
            two_d = 1'b0;
          end else begin
            rsp_d = bus_rdata;
            two_d = 1'b1;
          end
          state_d = TXB;
        end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
          rsp_d   = {RSP_ERR, 8'h00};
          two_d   = 1'b0;
          err_d   = 1'b1;
          state_d = TXB;
        end else begin
          ack_d = ack_q + AW'(1);
        end
      end
      TXB: begin
        if (rx_dv) err_d = 1'b1;
        if (!tx_active) begin
          tx_start_d = 1'b1;
          tx_byte_d  = rsp_q[15:8];
          seen_d     = 1'b0;
          wait_d     = '0;
          state_d    = TXW;
        end
      end
      TXW: begin
        if (rx_dv) err_d = 1'b1;
        if (tx_active) seen_d = 1'b1;
        if (tx_done) begin
          if (two_q) begin
            two_d   = 1'b0;
            rsp_d   = {rsp_q[7:0], 8'h00};
            state_d = TXB;
          end else begin
            state_d = IDLE;
          end
        end else if (!seen_q && wait_q != 3'd4) begin
          wait_d = wait_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= '0;
      two_q      <= 1'b0;
      err_q      <= 1'b0;
      gap_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      seen_q     <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_q      <= rsp_d;
      two_q      <= two_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      seen_q     <= seen_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_loader.sv
// Directed bench for uart_bus_loader: vector table of frames plus
// hand-written gap, overrun and reset sequences.
module tb_uart_bus_loader;

  localparam int GT = 24;
  localparam int AT = 10;

  logic        clk;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        bus_req;
  logic        bus_we;
  logic [22:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic        err;

  uart_bus_loader #(
    .GAP_TIMEOUT(GT),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_active(tx_active),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic        wr;
    logic [23:0] a;
    logic [15:0] d;
    logic [15:0] rd;
    int          dly;
    logic        mute;
    logic [22:0] ea;
    int          ntx;
    logic [7:0]  t0;
    logic [7:0]  t1;
    logic        eerr;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // bus responder / transmitter model state
  int          ack_dly = 3;
  logic        ack_en = 1'b1;
  logic [15:0] rdata_v = '0;
  int          req_cyc = 0;
  int          req_len = 0;
  int          nbus = 0;
  logic        stab_err = 1'b0;
  logic [22:0] cap_addr = '0;
  logic        cap_we = 1'b0;
  logic [15:0] cap_wd = '0;
  logic        tx_mute = 1'b0;
  int          tx_cnt = 0;
  logic [7:0]  txq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  initial begin
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_ack = 1'b0;
      bus_rdata = rdata_v;
      if (bus_req) begin
        req_cyc++;
        req_len = req_cyc;
        if (req_cyc == 1) begin
          nbus++;
          cap_addr = bus_addr;
          cap_we = bus_we;
          cap_wd = bus_wdata;
        end else if (bus_addr !== cap_addr ||
                     bus_we !== cap_we ||
                     bus_wdata !== cap_wd) begin
          stab_err = 1'b1;
        end
        if (ack_en && req_cyc == ack_dly)
          bus_ack = 1'b1;
      end else begin
        req_cyc = 0;
      end
    end
  end

  initial begin
    tx_active = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tx_cnt > 0) begin
        tx_cnt--;
        tx_active = (tx_cnt != 0);
      end
      if (tx_start) begin
        txq.push_back(tx_byte);
        if (!tx_mute) begin
          tx_active = 1'b1;
          tx_cnt = 5;
        end
      end
    end
  end

  // called at posedge+1, returns at posedge+1 after the byte is taken
  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] last;
    nbus = 0;
    txq.delete();
    stab_err = 1'b0;
    req_len = 0;
    ack_dly = v.dly;
    rdata_v = v.rd;
    tx_mute = v.mute;
    ack_en = 1'b1;
    send_byte(v.wr ? 8'h57 : 8'h52);
    send_byte(v.a[23:16]);
    send_byte(v.a[15:8]);
    if (v.wr) begin
      send_byte(v.a[7:0]);
      send_byte(v.d[15:8]);
      last = v.d[7:0];
    end else begin
      last = v.a[7:0];
    end
    @(negedge clk);
    chk($sformatf("v%0d_req_early", idx),
        {31'd0, bus_req}, 32'd0);
    @(posedge clk);
    #1;
    send_byte(last);
    @(negedge clk);
    chk($sformatf("v%0d_req_lat", idx),
        {31'd0, bus_req}, 32'd1);
    wait_idle($sformatf("v%0d_idle", idx));
    chk($sformatf("v%0d_nbus", idx), nbus, 1);
    chk($sformatf("v%0d_addr", idx),
        {9'd0, cap_addr}, {9'd0, v.ea});
    chk($sformatf("v%0d_we", idx),
        {31'd0, cap_we}, {31'd0, v.wr});
    if (v.wr)
      chk($sformatf("v%0d_wdata", idx),
          {16'd0, cap_wd}, {16'd0, v.d});
    chk($sformatf("v%0d_stable", idx),
        {31'd0, stab_err}, 32'd0);
    chk($sformatf("v%0d_reqlen", idx), req_len,
        (v.dly == 0) ? AT : v.dly);
    chk($sformatf("v%0d_ntx", idx), txq.size(), v.ntx);
    if (txq.size() > 0)
      chk($sformatf("v%0d_tx0", idx),
          {24'd0, txq[0]}, {24'd0, v.t0});
    if (v.ntx == 2 && txq.size() > 1)
      chk($sformatf("v%0d_tx1", idx),
          {24'd0, txq[1]}, {24'd0, v.t1});
    chk($sformatf("v%0d_err", idx),
        {31'd0, err}, {31'd0, v.eerr});
  endtask

  vec_t vt[8];
  vec_t vr;
  int   seen_tx;

  initial begin
    vt[0] = '{1'b1, 24'h001234, 16'hABCD, 16'h0000, 3, 1'b0,
              23'h00091A, 1, 8'h4B, 8'h00, 1'b0};
    vt[1] = '{1'b0, 24'h000008, 16'h0000, 16'h1234, 3, 1'b0,
              23'h000004, 2, 8'h12, 8'h34, 1'b0};
    vt[2] = '{1'b1, 24'hFFFFFF, 16'h0001, 16'h0000, 1, 1'b0,
              23'h7FFFFF, 1, 8'h4B, 8'h00, 1'b0};
    vt[3] = '{1'b0, 24'h800003, 16'h0000, 16'hA55A, 5, 1'b0,
              23'h400001, 2, 8'hA5, 8'h5A, 1'b0};
    vt[4] = '{1'b1, 24'h000010, 16'h5555, 16'h0000, 0, 1'b0,
              23'h000008, 1, 8'h45, 8'h00, 1'b1};
    vt[5] = '{1'b0, 24'h000020, 16'h0000, 16'h0000, 0, 1'b0,
              23'h000010, 1, 8'h45, 8'h00, 1'b1};
    vt[6] = '{1'b1, 24'h000002, 16'h1234, 16'h0000, 3, 1'b0,
              23'h000001, 1, 8'h4B, 8'h00, 1'b0};
    vt[7] = '{1'b0, 24'h000006, 16'h0000, 16'hC33C, 2, 1'b1,
              23'h000003, 2, 8'hC3, 8'h3C, 1'b0};

    rst = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_txs", {31'd0, tx_start}, 32'd0);
    chk("rst_addr", {9'd0, bus_addr}, 32'd0);
    chk("rst_wd", {16'd0, bus_wdata}, 32'd0);
    chk("rst_txb", {24'd0, tx_byte}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vt[i]);
      @(posedge clk);
      #1;
    end

    // gap timeout after a partial frame
    nbus = 0;
    txq.delete();
    tx_mute = 1'b0;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (GT - 2) @(negedge clk);
    chk("gap_busy_before", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("gap_busy", {31'd0, busy}, 32'd0);
    chk("gap_err", {31'd0, err}, 32'd1);
    chk("gap_nbus", nbus, 0);
    chk("gap_ntx", txq.size(), 0);
    @(posedge clk);
    #1;

    // junk bytes in IDLE, then overrun during TXW
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    chk("junk_busy", {31'd0, busy}, 32'd0);
    chk("junk_err", {31'd0, err}, 32'd1);
    @(posedge clk);
    #1;
    nbus = 0;
    txq.delete();
    rdata_v = 16'hBEEF;
    ack_dly = 2;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    @(negedge clk);
    chk("ovr_err_clr", {31'd0, err}, 32'd0);
    seen_tx = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txq.size() > 0) begin
        seen_tx = 1;
        break;
      end
    end
    chk("ovr_tx_seen", seen_tx, 1);
    @(posedge clk);
    #1;
    send_byte(8'h52);
    wait_idle("ovr_idle");
    chk("ovr_err", {31'd0, err}, 32'd1);
    chk("ovr_nbus", nbus, 1);
    chk("ovr_ntx", txq.size(), 2);
    if (txq.size() > 1) begin
      chk("ovr_tx0", {24'd0, txq[0]}, 32'h0000_00BE);
      chk("ovr_tx1", {24'd0, txq[1]}, 32'h0000_00EF);
    end
    @(posedge clk);
    #1;

    // reset while bus_req is high, then a normal frame
    ack_en = 1'b0;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    @(negedge clk);
    chk("rbus_req_hi", {31'd0, bus_req}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rbus_req", {31'd0, bus_req}, 32'd0);
    chk("rbus_busy", {31'd0, busy}, 32'd0);
    chk("rbus_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    vr = vt[0];
    run_vec(8, vr);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
